// File: rtl/a2d_pkg.sv
// Shared definitions for the two-frame SPI A2D interface: FSM encoding,
// frame geometry and the command-word builder used by both frames.
package a2d_pkg;

    localparam int SCLK_DIV_DEF = 32;
    localparam int GAP_CLKS     = 2;
    localparam int FRAME_BITS   = 16;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_FRM1 = 3'd1;
    localparam state_t ST_GAP  = 3'd2;
    localparam state_t ST_FRM2 = 3'd3;
    localparam state_t ST_DONE = 3'd4;

    // The ADC expects the channel number in bits [13:11]; all other bits are zero.
    function automatic logic [FRAME_BITS-1:0] adc_cmd(input logic [2:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

endpackage

// File: rtl/a2d_intf_spi_mstr16.sv
// One 16-bit SPI frame, CPOL=1/CPHA=1: MOSI changes on SCLK falls, MISO is
// captured on SCLK rises, SCLK idles high and SS_n frames the whole transfer.
module spi_mstr16
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV = SCLK_DIV_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wrt,
    input  logic [FRAME_BITS-1:0] i_cmd,
    output logic                  o_done,
    output logic [FRAME_BITS-1:0] o_rd_data,
    output logic                  o_ss_n,
    output logic                  o_sclk,
    output logic                  o_mosi,
    input  logic                  i_miso
);

    localparam int FRAME_CLKS = FRAME_BITS * SCLK_DIV + SCLK_DIV / 4 + 1;
    localparam int CNT_W      = $clog2(FRAME_CLKS);
    localparam int HALF_B     = $clog2(SCLK_DIV) - 1;

    // Counter value (clks since SS_n fell) of the first fall, the last rise
    // and the last clk of the frame.
    localparam logic [CNT_W-1:0] FIRST_FALL = CNT_W'(SCLK_DIV / 4 + 1);
    localparam logic [CNT_W-1:0] LAST_RISE  =
        CNT_W'(SCLK_DIV / 4 + 1 + (FRAME_BITS - 1) * SCLK_DIV + SCLK_DIV / 2);
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(FRAME_CLKS - 1);

    logic                  r_busy;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_ss_n;
    logic                  r_sclk;
    logic                  r_mosi;
    logic [FRAME_BITS-1:0] r_tx;
    logic [FRAME_BITS-1:0] r_rx;

    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [CNT_W-1:0]      w_phase;
    logic                  w_sclk_low_nxt;
    logic                  w_frm_end;
    logic                  w_rise;
    logic                  w_shift_tx;

    // NOTE: every signal driven here is assigned on every pass, so no latch can be inferred.
    always_comb begin
        w_cnt_nxt      = r_cnt + CNT_W'(1);
        w_phase        = w_cnt_nxt - FIRST_FALL;
        w_sclk_low_nxt = (w_cnt_nxt >= FIRST_FALL) && (w_cnt_nxt < LAST_RISE) &&
                         !w_phase[HALF_B];
        w_frm_end      = r_busy && (r_cnt == LAST_CNT);
        w_rise         = !r_sclk && !w_sclk_low_nxt;
        // The MSB is already on MOSI when SS_n falls, so the first fall keeps it.
        w_shift_tx     = r_sclk && w_sclk_low_nxt && (w_cnt_nxt != FIRST_FALL);
    end

    // NOTE: rst is synchronous and clears every register, shift registers included,
    // so a mid-frame reset puts the bus back to idle on the next clk.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_ss_n <= 1'b1;
            r_sclk <= 1'b1;
            r_mosi <= 1'b0;
            r_tx   <= '0;
            r_rx   <= '0;
        end else if (!r_busy) begin
            if (i_wrt) begin
                r_busy <= 1'b1;
                r_cnt  <= '0;
                r_ss_n <= 1'b0;
                r_sclk <= 1'b1;
                r_tx   <= i_cmd;
                r_mosi <= i_cmd[FRAME_BITS-1];
                r_rx   <= '0;
            end
        end else if (w_frm_end) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_ss_n <= 1'b1;
            r_sclk <= 1'b1;
            r_mosi <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_sclk <= !w_sclk_low_nxt;
            if (w_rise) begin
                r_rx <= {r_rx[FRAME_BITS-2:0], i_miso};
            end
            if (w_shift_tx) begin
                r_tx   <= {r_tx[FRAME_BITS-2:0], 1'b0};
                r_mosi <= r_tx[FRAME_BITS-2];
            end
        end
    end

    assign o_done    = w_frm_end;
    assign o_rd_data = r_rx;
    assign o_ss_n    = r_ss_n;
    assign o_sclk    = r_sclk;
    assign o_mosi    = r_mosi;

endmodule

// File: rtl/a2d_intf.sv
// A2D converter front end: one strt_cnv runs two SPI frames with the latched
// channel and returns the 12-bit result of the second frame.
module a2d_intf
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV = SCLK_DIV_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_strt_cnv,
    input  logic [2:0]  i_chnnl,
    output logic        o_cnv_cmplt,
    output logic [11:0] o_res,
    output logic        o_ss_n,
    output logic        o_sclk,
    output logic        o_mosi,
    input  logic        i_miso
);

    localparam int            GAP_W    = $clog2(GAP_CLKS + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);

    state_t                r_state;
    logic [2:0]            r_chnnl;
    logic [GAP_W-1:0]      r_gap_cnt;
    logic [11:0]           r_res;

    logic                  w_wrt;
    logic                  w_done;
    logic                  w_gap_end;
    logic [FRAME_BITS-1:0] w_cmd;
    logic [FRAME_BITS-1:0] w_rd_data;
    logic                  w_rd_data_unused;

    // The master needs one clk to drop SS_n, so each frame is requested on the
    // clk that leaves IDLE or GAP; that keeps SS_n low exactly in FRM1/FRM2.
    always_comb begin
        w_gap_end = (r_state == ST_GAP) && (r_gap_cnt == GAP_LAST);
        w_wrt     = ((r_state == ST_IDLE) && i_strt_cnv) || w_gap_end;
        w_cmd     = (r_state == ST_IDLE) ? adc_cmd(i_chnnl) : adc_cmd(r_chnnl);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_chnnl   <= '0;
            r_gap_cnt <= '0;
            r_res     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_strt_cnv) begin
                        r_state <= ST_FRM1;
                        r_chnnl <= i_chnnl;
                    end
                end
                ST_FRM1: begin
                    if (w_done) begin
                        r_state   <= ST_GAP;
                        r_gap_cnt <= '0;
                    end
                end
                ST_GAP: begin
                    if (w_gap_end) begin
                        r_state <= ST_FRM2;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                ST_FRM2: begin
                    if (w_done) begin
                        r_state <= ST_DONE;
                        r_res   <= w_rd_data[11:0];
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    spi_mstr16 #(
        .SCLK_DIV (SCLK_DIV)
    ) u_spi (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wrt     (w_wrt),
        .i_cmd     (w_cmd),
        .o_done    (w_done),
        .o_rd_data (w_rd_data),
        .o_ss_n    (o_ss_n),
        .o_sclk    (o_sclk),
        .o_mosi    (o_mosi),
        .i_miso    (i_miso)
    );

    // The ADC pads its 12-bit result with four leading bits we do not keep.
    assign w_rd_data_unused = ^w_rd_data[FRAME_BITS-1:12];

    assign o_cnv_cmplt = (r_state == ST_DONE);
    assign o_res       = r_res;

endmodule

// File: tb/tb_a2d_intf.sv
// Directed bench for a2d_intf with a behavioural SPI ADC and a bus monitor.
module tb_a2d_intf;

    logic        clk = 1'b0;
    logic        rst;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        ss_n;
    logic        sclk;
    logic        mosi;
    logic        miso;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    a2d_intf #(.SCLK_DIV(32)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_strt_cnv  (strt_cnv),
        .i_chnnl     (chnnl),
        .o_cnv_cmplt (cnv_cmplt),
        .o_res       (res),
        .o_ss_n      (ss_n),
        .o_sclk      (sclk),
        .o_mosi      (mosi),
        .i_miso      (miso)
    );

    // ADC model: odd frames of a transaction return junk, even frames the result.
    logic [11:0] adc_val   = 12'h000;
    int          frm_base  = 0;
    int          frm_cnt   = 0;
    logic [15:0] adc_word  = 16'h0000;
    int          adc_idx   = 15;
    bit          first_fall = 1'b0;
    logic        prev_ss_n = 1'b1;
    logic        prev_sclk = 1'b1;
    logic [15:0] mosi_sh   = 16'h0000;
    logic [15:0] mosi_last = 16'h0000;
    logic [15:0] mosi_prev = 16'h0000;
    int          rise_cnt  = 0;
    int          rises_last = 0;

    always @(ss_n or sclk) begin
        if (prev_ss_n === 1'b1 && ss_n === 1'b0) begin
            frm_cnt++;
            adc_word   = ((frm_cnt - frm_base) % 2 == 1) ? {4'hF, ~adc_val} : {4'h0, adc_val};
            adc_idx    = 15;
            first_fall = 1'b1;
            mosi_sh    = 16'h0000;
            rise_cnt   = 0;
        end else if (ss_n === 1'b0 && prev_sclk === 1'b1 && sclk === 1'b0) begin
            if (first_fall) first_fall = 1'b0;
            else if (adc_idx > 0) adc_idx--;
        end
        if (ss_n === 1'b0 && prev_sclk === 1'b0 && sclk === 1'b1) begin
            mosi_sh = {mosi_sh[14:0], mosi};
            rise_cnt++;
        end
        if (prev_ss_n === 1'b0 && ss_n === 1'b1) begin
            mosi_prev  = mosi_last;
            mosi_last  = mosi_sh;
            rises_last = rise_cnt;
        end
        prev_ss_n = ss_n;
        prev_sclk = sclk;
    end

    assign miso = adc_word[adc_idx];

    // Bus monitor: SS_n run lengths and SCLK idle level while deselected.
    int   hi_run = 0, lo_run = 0, last_gap = 0, last_frm_len = 0, sclk_bad = 0;
    logic mon_ss = 1'b1;

    always @(negedge clk) begin
        if (ss_n === 1'b1) begin
            if (mon_ss === 1'b0) begin
                last_frm_len = lo_run;
                hi_run = 0;
            end
            hi_run++;
            if (sclk !== 1'b1) sclk_bad++;
        end else if (ss_n === 1'b0) begin
            if (mon_ss === 1'b1) begin
                last_gap = hi_run;
                lo_run = 0;
            end
            lo_run++;
        end
        mon_ss = ss_n;
    end

    task automatic start_conv(input logic [2:0] ch, input logic [11:0] val);
        adc_val  = val;
        frm_base = frm_cnt;
        chnnl    = ch;
        strt_cnv = 1'b1;
        @(negedge clk);
        strt_cnv = 1'b0;
        chnnl    = ~ch;
    endtask

    task automatic wait_cmplt(input int start, output int lat);
        lat = start;
        while (cnv_cmplt !== 1'b1 && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; strt_cnv = 1'b0; chnnl = 3'd0;
        repeat (3) @(negedge clk);
        checks++; if (ss_n !== 1'b1) begin errors++; $display("FAIL reset_ss_n got %b want 1", ss_n); end
        checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL reset_sclk got %b want 1", sclk); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", mosi); end
        checks++; if (cnv_cmplt !== 1'b0) begin errors++; $display("FAIL reset_cmplt got %b want 0", cnv_cmplt); end
        checks++; if (res !== 12'h000) begin errors++; $display("FAIL reset_res got %h want 000", res); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single;
        int lat;
        start_conv(3'd3, 12'hA5C);
        wait_cmplt(1, lat);
        checks++; if (lat !== 1045) begin errors++; $display("FAIL single_latency got %0d want 1045", lat); end
        checks++; if (res !== 12'hA5C) begin errors++; $display("FAIL single_res got %h want a5c", res); end
        @(negedge clk);
        checks++; if (cnv_cmplt !== 1'b0) begin errors++; $display("FAIL single_pulse_width got %b want 0", cnv_cmplt); end
        checks++; if (res !== 12'hA5C) begin errors++; $display("FAIL single_res_hold got %h want a5c", res); end
        checks++; if (mosi_prev !== 16'h1800) begin errors++; $display("FAIL single_mosi_frm1 got %h want 1800", mosi_prev); end
        checks++; if (mosi_last !== 16'h1800) begin errors++; $display("FAIL single_mosi_frm2 got %h want 1800", mosi_last); end
        checks++; if (last_frm_len !== 521) begin errors++; $display("FAIL single_frame_len got %0d want 521", last_frm_len); end
        checks++; if (last_gap !== 2) begin errors++; $display("FAIL single_gap got %0d want 2", last_gap); end
        checks++; if (rises_last !== 16) begin errors++; $display("FAIL single_sclk_rises got %0d want 16", rises_last); end
        @(negedge clk);
    endtask

    task automatic test_sweep;
        int lat;
        logic [11:0] v;
        for (int c = 0; c < 8; c++) begin
            v = 12'(c * 257);
            start_conv(3'(c), v);
            wait_cmplt(1, lat);
            checks++; if (res !== v) begin errors++; $display("FAIL sweep_res ch%0d got %h want %h", c, res, v); end
            checks++; if (lat !== 1045) begin errors++; $display("FAIL sweep_latency ch%0d got %0d want 1045", c, lat); end
            @(negedge clk);
            checks++; if (mosi_last[13:11] !== 3'(c)) begin errors++; $display("FAIL sweep_mosi_frm2 ch%0d got %0d", c, mosi_last[13:11]); end
            checks++; if (mosi_prev[13:11] !== 3'(c)) begin errors++; $display("FAIL sweep_mosi_frm1 ch%0d got %0d", c, mosi_prev[13:11]); end
            checks++; if (last_gap !== 2) begin errors++; $display("FAIL sweep_gap ch%0d got %0d want 2", c, last_gap); end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore;
        int lat;
        int extra;
        start_conv(3'd2, 12'h2B7);
        repeat (199) @(negedge clk);
        chnnl = 3'd6; strt_cnv = 1'b1;
        @(negedge clk);
        strt_cnv = 1'b0;
        wait_cmplt(201, lat);
        checks++; if (lat !== 1045) begin errors++; $display("FAIL ignore_latency got %0d want 1045", lat); end
        checks++; if (res !== 12'h2B7) begin errors++; $display("FAIL ignore_res got %h want 2b7", res); end
        checks++; if (mosi_last !== 16'h1000) begin errors++; $display("FAIL ignore_mosi got %h want 1000", mosi_last); end
        // A request coinciding with the completion pulse must also be dropped.
        chnnl = 3'd6; strt_cnv = 1'b1;
        @(negedge clk);
        strt_cnv = 1'b0;
        extra = 0;
        repeat (1200) begin
            @(negedge clk);
            if (cnv_cmplt === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_extra_cmplt got %0d want 0", extra); end
        checks++; if (frm_cnt - frm_base !== 2) begin errors++; $display("FAIL ignore_frames got %0d want 2", frm_cnt - frm_base); end
    endtask

    task automatic test_reset_mid;
        int n;
        int lat;
        int extra;
        start_conv(3'd1, 12'h3C1);
        n = 0;
        while (frm_cnt - frm_base < 2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (frm_cnt - frm_base !== 2) begin errors++; $display("FAIL rstmid_reach_frm2 got %0d frames want 2", frm_cnt - frm_base); end
        repeat (299) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (ss_n !== 1'b1) begin errors++; $display("FAIL rstmid_ss_n got %b want 1", ss_n); end
        checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL rstmid_sclk got %b want 1", sclk); end
        checks++; if (res !== 12'h000) begin errors++; $display("FAIL rstmid_res got %h want 000", res); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL rstmid_mosi got %b want 0", mosi); end
        extra = 0;
        repeat (1500) begin
            @(negedge clk);
            if (cnv_cmplt === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL rstmid_cmplt got %0d pulses want 0", extra); end
        checks++; if (frm_cnt - frm_base !== 2) begin errors++; $display("FAIL rstmid_restart got %0d frames want 2", frm_cnt - frm_base); end
        start_conv(3'd5, 12'h5E5);
        wait_cmplt(1, lat);
        checks++; if (lat !== 1045) begin errors++; $display("FAIL rstmid_new_latency got %0d want 1045", lat); end
        checks++; if (res !== 12'h5E5) begin errors++; $display("FAIL rstmid_new_res got %h want 5e5", res); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int lat;
        int held_bad;
        int bad_base;
        bad_base = sclk_bad;
        start_conv(3'd4, 12'h404);
        wait_cmplt(1, lat);
        checks++; if (res !== 12'h404) begin errors++; $display("FAIL b2b_first_res got %h want 404", res); end
        @(negedge clk);
        start_conv(3'd7, 12'h7A7);
        lat = 1;
        held_bad = 0;
        while (cnv_cmplt !== 1'b1 && lat < 3000) begin
            if (res !== 12'h404) held_bad++;
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 1045) begin errors++; $display("FAIL b2b_latency got %0d want 1045", lat); end
        checks++; if (held_bad !== 0) begin errors++; $display("FAIL b2b_res_hold got %0d bad clks want 0", held_bad); end
        checks++; if (res !== 12'h7A7) begin errors++; $display("FAIL b2b_second_res got %h want 7a7", res); end
        @(negedge clk);
        checks++; if (mosi_last !== 16'h3800) begin errors++; $display("FAIL b2b_mosi got %h want 3800", mosi_last); end
        checks++; if (sclk_bad - bad_base !== 0) begin errors++; $display("FAIL b2b_sclk_idle got %0d bad clks want 0", sclk_bad - bad_base); end
    endtask

    initial begin
        rst = 1'b1;
        strt_cnv = 1'b0;
        chnnl = 3'd0;
        test_reset;
        test_single;
        test_sweep;
        test_ignore;
        test_reset_mid;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
